// File: rtl/prim_arb_rsp_pkg.sv
// Shared types and helpers for the arbiter response router: width helpers and
// the wrap-flag FIFO pointer with its increment.
package prim_arb_rsp_pkg;

  // Upper bound on log2(Depth); unused high address bits stay zero.
  localparam int unsigned PtrAddrW = 8;

  typedef struct packed {
    logic                wrap;
    logic [PtrAddrW-1:0] addr;
  } ptr_t;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic ptr_t ptr_inc(ptr_t p, int unsigned depth);
    ptr_t r;
    r = p;
    if (p.addr == PtrAddrW'(depth - 1)) begin
      r.addr = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.addr = p.addr + PtrAddrW'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/prim_arb_rsp_fifo.sv
// Grant-order FIFO: stores requester indices, decodes full/empty from the
// wrap-flag pointers and flags a push that finds no room.
module prim_arb_rsp_fifo
  import prim_arb_rsp_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned IdxW  = 3,
  parameter int unsigned CntW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  logic [IdxW-1:0] idx,
  input  logic            pop,
  output logic [IdxW-1:0] head,
  output logic            empty,
  output logic            full,
  output logic [CntW-1:0] cnt,
  output logic            err
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Depth-1:0][IdxW-1:0] mem_q;
  ptr_t                       wptr_q, rptr_q;
  logic                       err_q;
  logic                       do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q.addr == rptr_q.addr) && (wptr_q.wrap != rptr_q.wrap);
  assign head  = mem_q[rptr_q.addr[AW-1:0]];
  assign cnt   = CntW'({wptr_q.wrap, wptr_q.addr[AW-1:0]} - {rptr_q.wrap, rptr_q.addr[AW-1:0]});
  assign err   = err_q;

  // A pop frees the head slot this cycle, so a push while full is still legal.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q.addr[AW-1:0]] <= idx;
        wptr_q                     <= ptr_inc(wptr_q, Depth);
      end
      if (do_pop) rptr_q <= ptr_inc(rptr_q, Depth);
      if (push && full && !pop) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/prim_arb_rsp_router.sv
// Steers the shared response stream to the owner of the oldest outstanding
// grant. Optional same-cycle bypass on an empty FIFO: PRIM_ARB_RSP_ROUTER_BYPASS_EN.
module prim_arb_rsp_router
  import prim_arb_rsp_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned IdxW = idx_w(N),
  localparam int unsigned CntW = cnt_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_fire_i,
  input  logic [IdxW-1:0] req_idx_i,
  output logic            full_o,
  output logic [CntW-1:0] cnt_o,
  input  logic            rsp_valid_i,
  output logic            rsp_ready_o,
  input  logic [DW-1:0]   rsp_data_i,
  output logic [N-1:0]    rsp_valid_o,
  input  logic [N-1:0]    rsp_ready_i,
  output logic [DW-1:0]   rsp_data_o,
  output logic            err_o
);

  logic [IdxW-1:0] fifo_head, head;
  logic            fifo_empty, active, rsp_fire, push, pop;
  logic [N-1:0]    sel;

  assign rsp_fire = rsp_valid_i & rsp_ready_o;

`ifdef PRIM_ARB_RSP_ROUTER_BYPASS_EN
  logic byp;
  assign byp    = fifo_empty & req_fire_i;
  assign head   = byp ? req_idx_i : fifo_head;
  assign active = ~fifo_empty | byp;
  // A bypassed grant answered in the same cycle never enters the FIFO.
  assign push   = req_fire_i & ~(byp & rsp_fire);
  assign pop    = rsp_fire & ~fifo_empty;
`else
  assign head   = fifo_head;
  assign active = ~fifo_empty;
  assign push   = req_fire_i;
  assign pop    = rsp_fire;
`endif

  prim_arb_rsp_fifo #(
    .Depth (Depth),
    .IdxW  (IdxW),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .idx    (req_idx_i),
    .pop    (pop),
    .head   (fifo_head),
    .empty  (fifo_empty),
    .full   (full_o),
    .cnt    (cnt_o),
    .err    (err_o)
  );

  // An out-of-range head matches no lane, so the response stalls.
  for (genvar i = 0; i < N; i++) begin : g_sel
    assign sel[i] = active & (head == IdxW'(i));
  end

  assign rsp_valid_o = rsp_valid_i ? sel : '0;
  assign rsp_ready_o = |(sel & rsp_ready_i);
  assign rsp_data_o  = rsp_data_i;

`ifndef SYNTHESIS
  a_idx_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_fire_i |-> ({1'b0, req_idx_i} < (IdxW+1)'(N)));
  // Overflow is a reported condition (err_o), so this only warns.
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_fire_i |-> !full_o) else $warning("grant pushed while order FIFO full; dropped");
  a_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
`endif

endmodule

// File: tb/tb_prim_arb_rsp_router.sv
// Directed bench with a scoreboard: stimulus queues the expected one-hot route
// per grant, a negedge monitor checks every accepted response beat.
module tb_prim_arb_rsp_router;

  localparam int N = 8, DW = 32, Depth = 4, IdxW = 3, CntW = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_fire_i = 1'b0;
  logic [IdxW-1:0] req_idx_i = '0;
  logic            full_o;
  logic [CntW-1:0] cnt_o;
  logic            rsp_valid_i = 1'b0;
  logic            rsp_ready_o;
  logic [DW-1:0]   rsp_data_i = '0;
  logic [N-1:0]    rsp_valid_o;
  logic [N-1:0]    rsp_ready_i = '1;
  logic [DW-1:0]   rsp_data_o;
  logic            err_o;

  int checks = 0, errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;

  prim_arb_rsp_router #(.N(N), .DW(DW), .Depth(Depth)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_fire_i  (req_fire_i),
    .req_idx_i   (req_idx_i),
    .full_o      (full_o),
    .cnt_o       (cnt_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_data_i  (rsp_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  // Monitor: every accepted upstream beat must go to the next queued owner.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_i && rsp_ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got route %0h expected no beat", rsp_valid_o);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("beat_route", 32'(rsp_valid_o), 32'(mon_exp));
        chk("beat_data", rsp_data_o, rsp_data_i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with a response waiting upstream
    #12;
    rsp_valid_i = 1'b1;
    at_neg();
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_ready", 32'(rsp_ready_o), 32'd0);
    tick();
    rsp_valid_i = 1'b0;
    rst_ni = 1'b1;

    // In-order routing: idx 3 then 5
    tick(); req_fire_i = 1'b1; req_idx_i = 3'd3; exp_q.push_back(8'h08);
    tick(); req_idx_i = 3'd5; exp_q.push_back(8'h20);
    tick(); req_fire_i = 1'b0;
    at_neg(); chk("t1_cnt2", 32'(cnt_o), 32'd2);
    tick(); rsp_valid_i = 1'b1; rsp_data_i = 32'hA1;
    at_neg(); chk("t1_cnt2_pre", 32'(cnt_o), 32'd2);
    tick(); rsp_data_i = 32'hA2;
    at_neg(); chk("t1_cnt1", 32'(cnt_o), 32'd1);
    tick(); rsp_valid_i = 1'b0;
    at_neg(); chk("t1_cnt0", 32'(cnt_o), 32'd0);

    // Fill to Depth, then overflow push
    tick(); req_fire_i = 1'b1; req_idx_i = 3'd1; exp_q.push_back(8'h02);
    tick(); req_idx_i = 3'd2; exp_q.push_back(8'h04);
    tick(); req_idx_i = 3'd6; exp_q.push_back(8'h40);
    at_neg(); chk("t2_cnt2", 32'(cnt_o), 32'd2); chk("t2_notfull", 32'(full_o), 32'd0);
    tick(); req_idx_i = 3'd7; exp_q.push_back(8'h80);
    at_neg(); chk("t2_cnt3", 32'(cnt_o), 32'd3); chk("t2_notfull3", 32'(full_o), 32'd0);
    tick(); req_idx_i = 3'd0;
    at_neg(); chk("t2_full", 32'(full_o), 32'd1); chk("t2_cnt4", 32'(cnt_o), 32'd4);
    chk("t2_err_pre", 32'(err_o), 32'd0);
    tick(); req_fire_i = 1'b0;
    at_neg(); chk("t2_err", 32'(err_o), 32'd1); chk("t2_cnt4_ovf", 32'(cnt_o), 32'd4);
    chk("t2_full_ovf", 32'(full_o), 32'd1); chk("t2_head_ready", 32'(rsp_ready_o), 32'd1);
    chk("t2_novalid", 32'(rsp_valid_o), 32'h0);
    tick(); rsp_valid_i = 1'b1; rsp_data_i = 32'hB1;
    at_neg(); chk("t2_full_at_pop", 32'(full_o), 32'd1);
    tick(); rsp_data_i = 32'hB2;
    at_neg(); chk("t2_full_fall", 32'(full_o), 32'd0); chk("t2_cnt3_pop", 32'(cnt_o), 32'd3);
    tick(); rsp_data_i = 32'hB3;
    at_neg(); chk("t2_cnt2_pop", 32'(cnt_o), 32'd2);
    tick(); rsp_data_i = 32'hB4;
    at_neg(); chk("t2_cnt1_pop", 32'(cnt_o), 32'd1);
    tick(); rsp_valid_i = 1'b0;
    at_neg(); chk("t2_cnt0", 32'(cnt_o), 32'd0); chk("t2_err_sticky", 32'(err_o), 32'd1);

    // Stall: head idx 2 with its ready low for 3 cycles
    tick(); req_fire_i = 1'b1; req_idx_i = 3'd2; exp_q.push_back(8'h04);
    tick(); req_fire_i = 1'b0; rsp_valid_i = 1'b1; rsp_ready_i = 8'hFB; rsp_data_i = 32'hC3;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t3_stall_ready", 32'(rsp_ready_o), 32'd0);
      chk("t3_stall_valid", 32'(rsp_valid_o), 32'h04);
      chk("t3_stall_cnt", 32'(cnt_o), 32'd1);
      tick();
    end
    rsp_ready_i = 8'hFF;
    at_neg(); chk("t3_ready_up", 32'(rsp_ready_o), 32'd1);
    tick(); rsp_valid_i = 1'b0;
    at_neg(); chk("t3_cnt0", 32'(cnt_o), 32'd0);

    // Same-cycle push/pop at count 1; pointers wrap
    tick(); req_fire_i = 1'b1; req_idx_i = 3'd1; exp_q.push_back(8'h02);
    tick();
    begin
      logic [IdxW-1:0] vec [10];
      logic [N-1:0]    oh  [10];
      vec = '{3'd0, 3'd7, 3'd3, 3'd4, 3'd2, 3'd6, 3'd5, 3'd1, 3'd0, 3'd7};
      oh  = '{8'h01, 8'h80, 8'h08, 8'h10, 8'h04, 8'h40, 8'h20, 8'h02, 8'h01, 8'h80};
      for (int i = 0; i < 10; i++) begin
        req_idx_i = vec[i];
        exp_q.push_back(oh[i]);
        rsp_valid_i = 1'b1;
        rsp_data_i = 32'hE0 + 32'(i);
        at_neg(); chk("t4_cnt1", 32'(cnt_o), 32'd1);
        tick();
      end
    end
    req_fire_i = 1'b0;
    at_neg(); chk("t4_cnt1_drain", 32'(cnt_o), 32'd1);
    tick(); rsp_valid_i = 1'b0;
    at_neg(); chk("t4_cnt0", 32'(cnt_o), 32'd0); chk("t4_full", 32'(full_o), 32'd0);

    // Response while empty stalls
    rsp_valid_i = 1'b1; rsp_data_i = 32'hF5;
    at_neg(); chk("t5_ready", 32'(rsp_ready_o), 32'd0); chk("t5_valid", 32'(rsp_valid_o), 32'h0);
    tick();
    at_neg(); chk("t5_cnt", 32'(cnt_o), 32'd0); chk("t5_ready2", 32'(rsp_ready_o), 32'd0);
    tick(); rsp_valid_i = 1'b0;

    // Reset with 3 outstanding
    req_fire_i = 1'b1; req_idx_i = 3'd1;
    tick(); req_idx_i = 3'd2;
    tick(); req_idx_i = 3'd3;
    tick(); req_fire_i = 1'b0; rsp_valid_i = 1'b1; rsp_ready_i = '0;
    at_neg(); chk("t6_cnt3", 32'(cnt_o), 32'd3); chk("t6_valid", 32'(rsp_valid_o), 32'h02);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_drop", 32'(rsp_valid_o), 32'h0);
    chk("t6_rst_cnt", 32'(cnt_o), 32'd0);
    tick(); rst_ni = 1'b1; rsp_valid_i = 1'b0; rsp_ready_i = '1;
    at_neg();
    chk("t6_post_cnt", 32'(cnt_o), 32'd0);
    chk("t6_post_full", 32'(full_o), 32'd0);
    chk("t6_post_err", 32'(err_o), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
